fwd_hazard_ctrl: RTL

//  Forwarding/hazard controller for the 5-stage RV64 pipeline.

---
 rtl/fwd_hazard_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller for a 5-stage RV64 pipeline.
// Keeps a shadow copy of the register tags in ID/EX, EX/MEM and MEM/WB.
// From these tags it drives the EX operand-mux selects, the load-use stall,
// the pipeline bubbles and flushes, and a saturating stall-cycle counter.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall_if_id,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Mux select encoding shared by both EX operand muxes.
  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  // ID/EX shadow
  logic              ex_v_q,   ex_v_d;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
  logic              ex_u1_q,  ex_u1_d;
  logic              ex_u2_q,  ex_u2_d;
  logic [REG_AW-1:0] ex_rd_q,  ex_rd_d;
  logic              ex_rw_q,  ex_rw_d;
  logic              ex_mr_q,  ex_mr_d;
  // EX/MEM shadow
  logic              mem_v_q,  mem_v_d;
  logic [REG_AW-1:0] mem_rd_q, mem_rd_d;
  logic              mem_rw_q, mem_rw_d;
  // MEM/WB shadow
  logic              wb_v_q,   wb_v_d;
  logic [REG_AW-1:0] wb_rd_q,  wb_rd_d;
  logic              wb_rw_q,  wb_rw_d;
  // Performance counter
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic advance;
  logic load_use;
  logic mem_fwd_ok;
  logic wb_fwd_ok;
  logic stall_raw;
  logic flush_if_raw;
  logic flush_ex_raw;

  assign advance = !mem_busy;

  // Producers in MEM / WB that can legally supply a value (never x0).
  assign mem_fwd_ok = mem_v_q && mem_rw_q && (mem_rd_q != '0);
  assign wb_fwd_ok  = wb_v_q  && wb_rw_q  && (wb_rd_q  != '0);

  // A load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = 1'b0;
    if (ex_v_q && ex_mr_q && (ex_rd_q != '0) && id_valid) begin
      load_use = (id_use_rs1 && (id_rs1 == ex_rd_q)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd_q));
    end
  end

  // Per-operand forwarding select: MEM has the younger value, so it wins over WB.
  logic [REG_AW-1:0] ex_rs_w  [2];
  logic              ex_use_w [2];
  logic [1:0]        sel_w    [2];

  assign ex_rs_w[0]  = ex_rs1_q;
  assign ex_rs_w[1]  = ex_rs2_q;
  assign ex_use_w[0] = ex_u1_q;
  assign ex_use_w[1] = ex_u2_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      // Select source for operand gi from the shadow tags only.
      always_comb begin
        sel_w[gi] = SEL_RF;
        if (ex_use_w[gi] && mem_fwd_ok && (mem_rd_q == ex_rs_w[gi])) begin
          sel_w[gi] = SEL_MEM;
        end else if (ex_use_w[gi] && wb_fwd_ok && (wb_rd_q == ex_rs_w[gi])) begin
          sel_w[gi] = SEL_WB;
        end
      end
    end
  endgenerate

  assign fwd_a_sel = sel_w[0];
  assign fwd_b_sel = sel_w[1];

  // Control priority: memory freeze, then redirect (wrong-path hazards are moot), then load-use.
  always_comb begin
    stall_raw    = 1'b0;
    flush_if_raw = 1'b0;
    flush_ex_raw = 1'b0;
    if (mem_busy) begin
      stall_raw    = 1'b1;
    end else if (ex_redirect) begin
      flush_if_raw = 1'b1;
      flush_ex_raw = 1'b1;
    end else if (load_use) begin
      stall_raw    = 1'b1;
      flush_ex_raw = 1'b1;
    end
  end

  // Control outputs are forced low while reset is asserted, independent of the clock.
  assign stall_if_id = stall_raw    && rst_n;
  assign flush_if_id = flush_if_raw && rst_n;
  assign flush_id_ex = flush_ex_raw && rst_n;
  assign stall_cnt   = stall_cnt_q;

  // Shadow pipeline next state: shift on advance, hold everything on a memory freeze.
  always_comb begin
    ex_v_d   = ex_v_q;
    ex_rs1_d = ex_rs1_q;
    ex_rs2_d = ex_rs2_q;
    ex_u1_d  = ex_u1_q;
    ex_u2_d  = ex_u2_q;
    ex_rd_d  = ex_rd_q;
    ex_rw_d  = ex_rw_q;
    ex_mr_d  = ex_mr_q;
    mem_v_d  = mem_v_q;
    mem_rd_d = mem_rd_q;
    mem_rw_d = mem_rw_q;
    wb_v_d   = wb_v_q;
    wb_rd_d  = wb_rd_q;
    wb_rw_d  = wb_rw_q;
    if (advance) begin
      wb_v_d   = mem_v_q;
      wb_rd_d  = mem_rd_q;
      wb_rw_d  = mem_rw_q;
      mem_v_d  = ex_v_q;
      mem_rd_d = ex_rd_q;
      mem_rw_d = ex_rw_q;
      // A bubble or a flushed wrong-path instruction enters EX as invalid.
      ex_v_d   = id_valid && !load_use && !ex_redirect;
      ex_rs1_d = id_rs1;
      ex_rs2_d = id_rs2;
      ex_u1_d  = id_use_rs1;
      ex_u2_d  = id_use_rs2;
      ex_rd_d  = id_rd;
      ex_rw_d  = id_reg_write;
      ex_mr_d  = id_mem_read;
    end
  end

  // Stall counter next state: count stalled cycles, stick at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_id && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v_q      <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_u1_q     <= 1'b0;
      ex_u2_q     <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= '0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      ex_v_q      <= ex_v_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_u1_q     <= ex_u1_d;
      ex_u2_q     <= ex_u2_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      wb_v_q      <= wb_v_d;
      wb_rd_q     <= wb_rd_d;
      wb_rw_q     <= wb_rw_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
